// File: rtl/fetch_unit_if.sv
// Decode-side bus of the fetch stage: redirect controls, pop data, imem port and IF/ID outputs.
// Master is the fetch unit; slave is decode plus instruction memory.
interface fetch_unit_if #(
  parameter int width    = 16,
  parameter int pc_width = 32
);
  logic                fetch_pc_enable;
  logic [1:0]          pc_sel;
  logic [pc_width-1:0] pc_jmp;
  logic                pop_pc1;
  logic                pop_pc2;
  logic [width-1:0]    mem_data;
  logic [pc_width-1:0] imem_addr;
  logic [width-1:0]    imem_data;
  logic [width-1:0]    instruction;
  logic                instr_valid;
  logic                imm_word;
  logic [pc_width-1:0] pc_out;
  logic                busy;

  modport master (
    input  fetch_pc_enable, pc_sel, pc_jmp, pop_pc1, pop_pc2, mem_data, imem_data,
    output imem_addr, instruction, instr_valid, imm_word, pc_out, busy
  );

  modport slave (
    output fetch_pc_enable, pc_sel, pc_jmp, pop_pc1, pop_pc2, mem_data, imem_data,
    input  imem_addr, instruction, instr_valid, imm_word, pc_out, busy
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC and IF/ID register, loads reset/interrupt vectors, applies decode redirects.
// Latency 1 edge imem->instruction; fetch_pc_enable=0 stalls PC and IF/ID, redirects always win.
module fetch_unit #(
  parameter int                  width        = 16,
  parameter int                  pc_width     = 32,
  parameter logic [pc_width-1:0] RESET_VEC    = '0,
  parameter logic [pc_width-1:0] INT_VEC      = pc_width'(2),
  parameter logic [31:0]         TWO_WORD_OPS = 32'h0000_7000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {RST_HI, RST_LO, RUN, VEC_HI, VEC_LO} state_t;

  state_t              state_q, state_d;
  logic [pc_width-1:0] pc_q, pc_d;
  logic [width-1:0]    hi_q, hi_d;
  logic [width-1:0]    pop_hi_q, pop_hi_d;
  logic [width-1:0]    instr_q, instr_d;
  logic                vld_q, vld_d;
  logic                imm_q, imm_d;
  logic                pend_q, pend_d;
  logic [pc_width-1:0] pc_out_q, pc_out_d;
  logic [pc_width-1:0] imem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RST_HI;
      pc_q     <= '0;
      hi_q     <= '0;
      pop_hi_q <= '0;
      instr_q  <= '0;
      vld_q    <= 1'b0;
      imm_q    <= 1'b0;
      pend_q   <= 1'b0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hi_q     <= hi_d;
      pop_hi_q <= pop_hi_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
      imm_q    <= imm_d;
      pend_q   <= pend_d;
      pc_out_q <= pc_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hi_d      = hi_q;
    instr_d   = instr_q;
    vld_d     = vld_q;
    imm_d     = imm_q;
    pend_d    = pend_q;
    pc_out_d  = pc_out_q;
    imem_addr = pc_q;
    // The popped high half can arrive in any state, ahead of the redirect itself.
    pop_hi_d  = bus.pop_pc1 ? bus.mem_data : pop_hi_q;

    case (state_q)
      RST_HI: begin
        imem_addr = RESET_VEC;
        hi_d      = bus.imem_data;
        state_d   = RST_LO;
      end
      RST_LO: begin
        imem_addr = RESET_VEC + pc_width'(1);
        pc_d      = pc_width'({hi_q, bus.imem_data});
        state_d   = RUN;
      end
      RUN: begin
        imem_addr = pc_q;
        if (bus.pc_sel != 2'b00) begin
          instr_d = '0;
          vld_d   = 1'b0;
          imm_d   = 1'b0;
        end
        if (bus.pc_sel == 2'b11) begin
          state_d = VEC_HI;
          pend_d  = 1'b0;
        end else if (bus.pc_sel == 2'b01) begin
          pc_d   = bus.pc_jmp;
          pend_d = 1'b0;
        end else if (bus.pc_sel == 2'b10) begin
          if (bus.pop_pc2) begin
            pc_d   = pc_width'({pop_hi_q, bus.mem_data});
            pend_d = 1'b0;
          end
        end else if (bus.fetch_pc_enable) begin
          pc_d     = pc_q + pc_width'(1);
          instr_d  = bus.imem_data;
          pc_out_d = pc_q;
          vld_d    = 1'b1;
          // An immediate word is never decoded as an opcode, so it cannot arm the flag itself.
          if (pend_q) begin
            imm_d  = 1'b1;
            pend_d = 1'b0;
          end else begin
            imm_d  = 1'b0;
            pend_d = TWO_WORD_OPS[bus.imem_data[width-1 -: 5]];
          end
        end
      end
      VEC_HI: begin
        imem_addr = INT_VEC;
        hi_d      = bus.imem_data;
        instr_d   = '0;
        vld_d     = 1'b0;
        imm_d     = 1'b0;
        state_d   = VEC_LO;
      end
      VEC_LO: begin
        imem_addr = INT_VEC + pc_width'(1);
        pc_d      = pc_width'({hi_q, bus.imem_data});
        instr_d   = '0;
        vld_d     = 1'b0;
        imm_d     = 1'b0;
        state_d   = RUN;
      end
      default: state_d = RST_HI;
    endcase
  end

  assign bus.imem_addr   = imem_addr;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.imm_word    = imm_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.busy        = (state_q != RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset vector, two-word stall, branch, pop, interrupt, wrap, async reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] imem [0:255];

  fetch_unit_if #(.width(16), .pc_width(32)) bus ();

  fetch_unit #(
    .width(16), .pc_width(32), .RESET_VEC(32'd0), .INT_VEC(32'd2), .TWO_WORD_OPS(32'h0000_7000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = imem[bus.imem_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h0000;
    imem[8'h01] = 16'h0010;
    imem[8'h02] = 16'h0000;
    imem[8'h03] = 16'h0080;
    imem[8'h10] = 16'h1234;  // opcode 2: single word
    imem[8'h20] = 16'h6000;  // opcode 12: two-word
    imem[8'h21] = 16'h00AB;
    imem[8'h22] = 16'h0822;
    imem[8'h40] = 16'h4040;
    imem[8'h80] = 16'h0880;
    imem[8'hFF] = 16'h08FF;

    bus.fetch_pc_enable = 1'b1;
    bus.pc_sel   = 2'b00;
    bus.pc_jmp   = '0;
    bus.pop_pc1  = 1'b0;
    bus.pop_pc2  = 1'b0;
    bus.mem_data = '0;

    repeat (2) @(negedge clk);
    check("rst_busy",   bus.busy,        1);
    check("rst_instr",  bus.instruction, 0);
    check("rst_vld",    bus.instr_valid, 0);
    check("rst_imm",    bus.imm_word,    0);
    check("rst_pcout",  bus.pc_out,      0);
    check("rst_addr",   bus.imem_addr,   0);

    rst = 1'b1;
    step();
    check("e1_busy", bus.busy, 1);
    check("e1_addr", bus.imem_addr, 1);
    step();
    check("e2_busy", bus.busy, 0);
    check("e2_addr", bus.imem_addr, 32'h10);
    check("e2_vld",  bus.instr_valid, 0);
    step();
    check("e3_instr", bus.instruction, 16'h1234);
    check("e3_vld",   bus.instr_valid, 1);
    check("e3_pcout", bus.pc_out, 32'h10);
    check("e3_imm",   bus.imm_word, 0);

    bus.pc_sel = 2'b01; bus.pc_jmp = 32'h20;
    step();
    check("br1_vld",   bus.instr_valid, 0);
    check("br1_instr", bus.instruction, 0);
    check("br1_pcout", bus.pc_out, 32'h10);
    check("br1_addr",  bus.imem_addr, 32'h20);
    bus.pc_sel = 2'b00;
    step();
    check("op_instr", bus.instruction, 16'h6000);
    check("op_pcout", bus.pc_out, 32'h20);
    check("op_imm",   bus.imm_word, 0);

    bus.fetch_pc_enable = 1'b0;
    repeat (3) step();
    check("stall_pcout", bus.pc_out, 32'h20);
    check("stall_addr",  bus.imem_addr, 32'h21);
    check("stall_imm",   bus.imm_word, 0);
    bus.fetch_pc_enable = 1'b1;
    step();
    check("immw_instr", bus.instruction, 16'h00AB);
    check("immw_imm",   bus.imm_word, 1);
    check("immw_pcout", bus.pc_out, 32'h21);
    step();
    check("after_instr", bus.instruction, 16'h0822);
    check("after_imm",   bus.imm_word, 0);
    check("after_pcout", bus.pc_out, 32'h22);

    bus.pc_sel = 2'b01; bus.pc_jmp = 32'h40;
    step();
    check("br2_vld",   bus.instr_valid, 0);
    check("br2_pcout", bus.pc_out, 32'h22);
    bus.pc_sel = 2'b00;
    step();
    check("br2_tgt_pcout", bus.pc_out, 32'h40);
    check("br2_tgt_vld",   bus.instr_valid, 1);
    check("br2_tgt_instr", bus.instruction, 16'h4040);

    bus.pc_sel = 2'b10; bus.pop_pc1 = 1'b1; bus.mem_data = 16'h0001;
    step();
    check("pop1_vld",  bus.instr_valid, 0);
    check("pop1_addr", bus.imem_addr, 32'h41);
    bus.pop_pc1 = 1'b0; bus.mem_data = 16'hBEEF;
    step();
    check("popidle_vld",  bus.instr_valid, 0);
    check("popidle_addr", bus.imem_addr, 32'h41);
    bus.pop_pc2 = 1'b1; bus.mem_data = 16'h0200;
    step();
    check("pop2_addr", bus.imem_addr, 32'h0001_0200);
    check("pop2_vld",  bus.instr_valid, 0);
    bus.pop_pc2 = 1'b0; bus.pc_sel = 2'b00;
    step();
    check("pop_pcout", bus.pc_out, 32'h0001_0200);
    check("pop_vld",   bus.instr_valid, 1);

    bus.pc_sel = 2'b11;
    step();
    check("vhi_busy", bus.busy, 1);
    check("vhi_vld",  bus.instr_valid, 0);
    check("vhi_addr", bus.imem_addr, 2);
    bus.pc_sel = 2'b01; bus.pc_jmp = 32'h55;
    step();
    check("vlo_busy", bus.busy, 1);
    check("vlo_addr", bus.imem_addr, 3);
    step();
    check("vec_busy", bus.busy, 0);
    check("vec_addr", bus.imem_addr, 32'h80);
    check("vec_vld",  bus.instr_valid, 0);
    bus.pc_sel = 2'b00;
    step();
    check("vec_pcout", bus.pc_out, 32'h80);
    check("vec_vld1",  bus.instr_valid, 1);
    check("vec_instr", bus.instruction, 16'h0880);

    bus.pc_sel = 2'b01; bus.pc_jmp = 32'hFFFF_FFFF;
    step();
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFF);
    bus.pc_sel = 2'b00;
    step();
    check("wrap_pcout", bus.pc_out, 32'hFFFF_FFFF);
    check("wrap_addr",  bus.imem_addr, 0);
    check("wrap_instr", bus.instruction, 16'h08FF);

    bus.pc_sel = 2'b11;
    step();
    bus.pc_sel = 2'b00;
    step();
    check("mid_busy", bus.busy, 1);
    check("mid_addr", bus.imem_addr, 3);
    rst = 1'b0;
    #1;
    check("arst_busy",  bus.busy,        1);
    check("arst_instr", bus.instruction, 0);
    check("arst_vld",   bus.instr_valid, 0);
    check("arst_imm",   bus.imm_word,    0);
    check("arst_pcout", bus.pc_out,      0);
    check("arst_addr",  bus.imem_addr,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
